alu_seq_ctrl: RTL

- Moore FSM that sequences the shared 16-bit ALU datapath (register file, A/B/C pipeline registers, status register) for one register-to-register operation at a time.
- Accepts a command (ALUop, Rd, Rn, Rm) via a start/busy handshake.
- Drives register-file read/write selects and pipeline-register load enables, then pulses done.
- Sits between the instruction decoder and the datapath.

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_seq_ctrl_if.sv | 27 ++
 rtl/alu_seq_decode.sv | 61 ++++++
 rtl/alu_seq_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: ALU opcodes, FSM state
// codes, the control-vector layout and the default register-address width.
package alu_seq_pkg;

  // Default register-file address width (8 registers).
  localparam int REG_AW_DEFAULT = 3;

  // ALU operation codes as seen by the datapath ALU.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_AND  = 2'b10,
    OP_NOTB = 2'b11
  } op_t;

  // Sequencer states. Codes 3'd6 and 3'd7 are illegal and recover to S_WAIT.
  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_GETA = 3'd1,
    S_GETB = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Single-bit controls decoded from the state. Address and opcode outputs
  // live outside the struct so that their width can follow REG_AW.
  typedef struct packed {
    logic busy;
    logic done;
    logic write;
    logic loada;
    logic loadb;
    logic loadc;
    logic loads;
    logic asel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // NOT B only needs the B operand, so it skips the A fetch.
  function automatic state_t first_state(op_t op);
    return (op == OP_NOTB) ? S_GETB : S_GETA;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command handshake between the instruction decoder (master) and the ALU
// sequencer (slave): a start/busy/done handshake carrying op, rd, rn, rm.
interface alu_seq_ctrl_if #(
  parameter int REG_AW = alu_seq_pkg::REG_AW_DEFAULT
) ();

  logic              start;
  logic [1:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rn;
  logic [REG_AW-1:0] rm;
  logic              busy;
  logic              done;

  // Instruction decoder side: issues commands, watches busy/done.
  modport master (
    output start, op, rd, rn, rm,
    input  busy, done
  );

  // Sequencer side: accepts commands, reports busy/done.
  modport slave (
    input  start, op, rd, rn, rm,
    output busy, done
  );

endinterface

// File: rtl/alu_seq_decode.sv
// Combinational state-to-control decoder for the ALU sequencer. Every output
// depends only on the state register and the latched command, never on the
// live command inputs.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  state_t            state,
  input  op_t               op,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  output ctrl_t             ctrl,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output op_t               alu_op
);

  // Decode the current state into enables, register selects and the ALU op.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    ctrl     = CTRL_IDLE;
    readnum  = '0;
    writenum = '0;
    alu_op   = OP_ADD;

    if (state != S_WAIT) begin
      ctrl.busy = 1'b1;
      alu_op    = op;
    end

    case (state)
      S_GETA: begin
        readnum    = rn;
        ctrl.loada = 1'b1;
      end
      S_GETB: begin
        readnum    = rm;
        ctrl.loadb = 1'b1;
      end
      S_EXEC: begin
        ctrl.loadc = 1'b1;
        ctrl.loads = 1'b1;
        ctrl.asel  = (op == OP_NOTB);
      end
      S_WB: begin
        writenum   = rd;
        ctrl.write = 1'b1;
      end
      S_DONE: begin
        ctrl.done = 1'b1;
      end
      default: begin
        // S_WAIT and illegal codes: no enables.
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: a Moore FSM that runs one register-to-register operation on
// the shared 16-bit datapath (fetch A, fetch B, execute, write back, done).
// Optional feature macro: ALU_SEQ_OPCNT_EN adds a 16-bit completed-operation
// counter on the op_count port.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_seq_ctrl_if.slave     cmd,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic [1:0]        alu_op
`ifdef ALU_SEQ_OPCNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  state_t            state;
  op_t               op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rn_q;
  logic [REG_AW-1:0] rm_q;

  ctrl_t             ctrl;
  op_t               dec_alu_op;

  // State register and command latch; the command is captured only on the
  // edge that leaves S_WAIT, so start while busy has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= S_WAIT;
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cmd.start) begin
            op_q  <= op_t'(cmd.op);
            rd_q  <= cmd.rd;
            rn_q  <= cmd.rn;
            rm_q  <= cmd.rm;
            state <= first_state(op_t'(cmd.op));
          end
        end
        S_GETA:  state <= S_GETB;
        S_GETB:  state <= S_EXEC;
        S_EXEC:  state <= S_WB;
        S_WB:    state <= S_DONE;
        S_DONE:  state <= S_WAIT;
        default: state <= S_WAIT;
      endcase
    end
  end

`ifdef ALU_SEQ_OPCNT_EN
  // Completed-operation counter: bumps on the S_WB -> S_DONE step (S_WB always
  // moves to S_DONE) and wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (state == S_WB) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

  alu_seq_decode #(
    .REG_AW (REG_AW)
  ) u_decode (
    .state    (state),
    .op       (op_q),
    .rd       (rd_q),
    .rn       (rn_q),
    .rm       (rm_q),
    .ctrl     (ctrl),
    .readnum  (readnum),
    .writenum (writenum),
    .alu_op   (dec_alu_op)
  );

  // Unpack the decoded control vector onto the ports.
  assign cmd.busy = ctrl.busy;
  assign cmd.done = ctrl.done;
  assign write    = ctrl.write;
  assign loada    = ctrl.loada;
  assign loadb    = ctrl.loadb;
  assign loadc    = ctrl.loadc;
  assign loads    = ctrl.loads;
  assign asel     = ctrl.asel;
  assign alu_op   = dec_alu_op;

endmodule
